// File: rtl/keypad_entry.sv
// 4x4 hex keypad scanner: one-cold active-low row drive, synchronized column sense,
// full-scan debounce FSM, and a 16-bit nibble shift register of accepted key codes.
module keypad_entry #(
  parameter int unsigned SCAN_DIV = 10000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [15:0] number,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int unsigned     DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB      = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    HELD,
    RELEASE
  } state_t;

  logic [3:0]       col_s1_q, col_s1_d;
  logic [3:0]       col_s2_q, col_s2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       row_q, row_d;
  logic [3:0][3:0]  samp_q, samp_d;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic             accept_q, accept_d;
  logic [15:0]      number_q, number_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;

  logic        scan_edge;
  logic        eval;
  logic [1:0]  row_idx;
  logic [15:0] scan_low;
  logic [4:0]  low_cnt;
  logic [3:0]  low_idx;
  logic        is_none;
  logic        is_single;
  logic        cand_match;
  logic [3:0]  cnt_inc;

  always_comb begin
    col_s1_d  = col;
    col_s2_d  = col_s1_q;

    scan_edge = (div_q == DIV_LAST);
    div_d     = scan_edge ? '0 : div_q + DIV_W'(1);
    row_d     = scan_edge ? {row_q[2:0], row_q[3]} : row_q;

    unique case (row_q)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      default: row_idx = 2'd3;
    endcase

    samp_d = samp_q;
    if (scan_edge) begin
      samp_d[row_idx] = col_s2_q;
    end
    eval = scan_edge && (row_idx == 2'd3);

    // Row 3 is classified from the value being latched on this very edge.
    scan_low = ~{col_s2_q, samp_q[2], samp_q[1], samp_q[0]};
    low_cnt  = '0;
    low_idx  = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (scan_low[i]) begin
        low_cnt = low_cnt + 5'd1;
        low_idx = 4'(i);
      end
    end
    is_none    = (low_cnt == 5'd0);
    is_single  = (low_cnt == 5'd1);
    cand_match = is_single && (low_idx == cand_q);
    cnt_inc    = cnt_q + 4'd1;

    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept_d = 1'b0;

    if (eval) begin
      unique case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d = low_idx;
            if (DEB == 4'd1) begin
              accept_d = 1'b1;
              state_d  = HELD;
              cnt_d    = '0;
            end else begin
              state_d  = PRESS;
              cnt_d    = 4'd1;
            end
          end
        end
        PRESS: begin
          if (cand_match) begin
            if (cnt_inc == DEB) begin
              accept_d = 1'b1;
              state_d  = HELD;
              cnt_d    = '0;
            end else begin
              cnt_d    = cnt_inc;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (is_none) begin
            if (DEB == 4'd1) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = RELEASE;
              cnt_d   = 4'd1;
            end
          end
        end
        RELEASE: begin
          if (is_none) begin
            if (cnt_inc == DEB) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_inc;
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs follow one edge after the accepting evaluation.
    number_d    = accept_q ? {number_q[11:0], cand_q} : number_q;
    key_code_d  = accept_q ? cand_q : key_code_q;
    key_valid_d = accept_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_s1_q    <= 4'b1111;
      col_s2_q    <= 4'b1111;
      div_q       <= '0;
      row_q       <= 4'b1110;
      samp_q      <= '1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      accept_q    <= 1'b0;
      number_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      col_s1_q    <= col_s1_d;
      col_s2_q    <= col_s2_d;
      div_q       <= div_d;
      row_q       <= row_d;
      samp_q      <= samp_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      accept_q    <= accept_d;
      number_q    <= number_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign row       = row_q;
  assign number    = number_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: matrix keypad model, scan-level debounce reference model,
// directed test-plan phases followed by randomized key activity with occasional resets.
module tb_keypad_entry;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEBOUNCE = 2;
  localparam int          SCAN_CYC = 4 * SCAN_DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] number;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] keys = '0;

  always #5 clock = ~clock;

  keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clock    (clock),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .number   (number),
    .key_code (key_code),
    .key_valid(key_valid)
  );

  // Closed key (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && keys[4*r+c]) col[c] = 1'b0;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: stamps are scan_no*16 + position inside the scan window.
  int         scan_no = 0;
  int         pos = 0;
  int         obs_stamp[$];
  logic [3:0] obs_code[$];
  int         long_cnt = 0;
  logic       kv_prev = 1'b0;

  always @(negedge clock) begin
    if (key_valid === 1'b1) begin
      obs_stamp.push_back(scan_no * SCAN_CYC + pos);
      obs_code.push_back(key_code);
      if (kv_prev) long_cnt++;
    end
    kv_prev = (key_valid === 1'b1);
  end

  // Reference model: per-scan run lengths of identical single keys and of empty scans.
  bit         armed = 1'b1;
  int         run_len = 0;
  int         run_key = 0;
  int         none_run = 0;
  bit         pend = 1'b0;
  logic [3:0] pend_code = '0;
  logic [15:0] m_number = '0;
  logic [3:0] m_code = '0;
  int         exp_stamp[$];
  logic [3:0] exp_code[$];
  int         obs_rd = 0;
  int         exp_rd = 0;

  task automatic model_scan(input logic [15:0] k);
    int n;
    int idx;
    n = $countones(k);
    idx = (n == 1) ? $clog2(k) : -1;
    if (armed) begin
      if (run_len > 0) begin
        if (n == 1 && idx == run_key) run_len++;
        else run_len = 0;
      end else if (n == 1) begin
        run_key = idx;
        run_len = 1;
      end
      if (run_len == DEBOUNCE) begin
        pend      = 1'b1;
        pend_code = 4'(run_key);
        armed     = 1'b0;
        run_len   = 0;
        none_run  = 0;
      end
    end else begin
      if (n == 0) none_run++;
      else none_run = 0;
      if (none_run == DEBOUNCE) begin
        armed    = 1'b1;
        none_run = 0;
      end
    end
  endtask

  task automatic model_reset();
    armed    = 1'b1;
    run_len  = 0;
    none_run = 0;
    pend     = 1'b0;
    m_number = '0;
    m_code   = '0;
  endtask

  task automatic scan_step(input logic [15:0] k);
    logic [3:0] er;
    if (pend) begin
      m_number = {m_number[11:0], pend_code};
      m_code   = pend_code;
      exp_stamp.push_back(scan_no * SCAN_CYC + 1);
      exp_code.push_back(pend_code);
      pend = 1'b0;
    end
    keys = k;
    for (int i = 0; i < SCAN_CYC; i++) begin
      @(negedge clock);
      er = ~(4'b0001 << (i / SCAN_DIV));
      check("row", 32'(row), 32'(er));
      @(posedge clock);
      #1;
      pos = i + 1;
    end
    model_scan(k);
    scan_no++;
    pos = 0;
  endtask

  task automatic scans(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) scan_step(k);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    scan_no++;
    pos = 0;
    check("rst_row", 32'(row), 32'h0000000E);
    check("rst_number", 32'(number), 32'h0);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
  endtask

  task automatic checkpoint(input string tag);
    int no;
    int ne;
    no = obs_stamp.size() - obs_rd;
    ne = exp_stamp.size() - exp_rd;
    check({tag, ".number"}, 32'(number), 32'(m_number));
    check({tag, ".key_code"}, 32'(key_code), 32'(m_code));
    check({tag, ".pulse_cnt"}, 32'(no), 32'(ne));
    check({tag, ".pulse_width"}, 32'(long_cnt), 32'h0);
    for (int i = 0; i < ((no < ne) ? no : ne); i++) begin
      check({tag, ".pulse_time"}, 32'(obs_stamp[obs_rd+i]), 32'(exp_stamp[exp_rd+i]));
      check({tag, ".pulse_code"}, 32'(obs_code[obs_rd+i]), 32'(exp_code[exp_rd+i]));
    end
    obs_rd = obs_stamp.size();
    exp_rd = exp_stamp.size();
  endtask

  task automatic phase_end(input string tag, input int want_pulses);
    check({tag, ".pulses"}, 32'(obs_stamp.size() - obs_rd), 32'(want_pulses));
    checkpoint(tag);
  endtask

  function automatic logic [15:0] key_bit(input int code);
    logic [15:0] one;
    one = 16'h0001;
    return one << code;
  endfunction

  initial begin
    logic [15:0] k;
    logic [15:0] prev_k;
    int a;
    int b;
    int mode;

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    check("init_row", 32'(row), 32'h0000000E);
    check("init_number", 32'(number), 32'h0);
    check("init_key_valid", 32'(key_valid), 32'h0);

    scans('0, 2);
    phase_end("idle", 0);

    scans(key_bit(6), 5);
    scans('0, 3);
    phase_end("hold6", 1);
    check("hold6.number_const", 32'(number), 32'h0006);
    check("hold6.code_const", 32'(key_code), 32'h6);

    for (int c = 1; c <= 5; c++) begin
      scans(key_bit(c), 3);
      scans('0, 3);
    end
    phase_end("seq12345", 5);
    check("seq.number_const", 32'(number), 32'h2345);

    scans(key_bit(3), 1);
    scans('0, 3);
    phase_end("glitch1", 0);

    scans(key_bit(0) | key_bit(9), 4);
    scans('0, 3);
    phase_end("multi", 0);
    check("multi.number_const", 32'(number), 32'h2345);

    scans(key_bit(15), 3);
    scans('0, 1);
    scans(key_bit(15), 2);
    scans('0, 3);
    phase_end("bounce", 1);
    check("bounce.code_const", 32'(key_code), 32'hF);
    check("bounce.number_const", 32'(number), 32'h345F);

    scans(key_bit(8), 1);
    do_reset();
    phase_end("rst_mid", 0);
    scans(key_bit(8), 3);
    scans('0, 3);
    phase_end("rst_rearm", 1);
    check("rst_rearm.number_const", 32'(number), 32'h0008);

    // Reset lands on the same edge the accepted key would be published.
    scans(key_bit(10), 2);
    do_reset();
    scans('0, 3);
    phase_end("rst_accept", 0);
    check("rst_accept.number_const", 32'(number), 32'h0);

    prev_k = '0;
    for (int s = 0; s < 150; s++) begin
      mode = $urandom_range(0, 9);
      if (mode <= 3) begin
        k = prev_k;
      end else if (mode <= 5) begin
        k = '0;
      end else if (mode <= 7) begin
        k = key_bit($urandom_range(0, 15));
      end else if (mode == 8) begin
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        if (a == b) b = (a + 1) % 16;
        k = key_bit(a) | key_bit(b);
      end else begin
        k = key_bit($urandom_range(0, 2));
      end
      scan_step(k);
      prev_k = k;
      if ($urandom_range(0, 39) == 0) do_reset();
      checkpoint("rand");
    end
    scans('0, 3);
    checkpoint("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
